if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID register. Owns the PC and issues one word
//  request at a time to instruction memory over a req/ack handshake. Presents
//  fetched {if_pc, if_inst, if_valid} to IF/ID. Honours pipeline stall and branch redirect
//  from ID. Requests a pipeline stall while a fetch is outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  PC_STEP    4              byte increment per sequential fetch
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  stall          in   1   pipeline hold from ctrl; IF/ID also holds
//  branch_flag    in   1   ID redirect request, valid for one cycle
//  branch_target  in   32  redirect address; bits [1:0] ignored (forced 0)
//  mem_req        out  1   instruction-memory request
//  mem_addr       out  32  request address; stable while mem_req=1 and no ack
//  mem_ack        in   1   memory returns mem_rdata this cycle; sampled only when mem_req=1
//  mem_rdata      in   32  instruction word
//  if_pc          out  32  PC of presented instruction
//  if_inst        out  32  presented instruction; ZeroWord (nop) when if_valid=0
//  if_valid       out  1   if_pc/if_inst hold a live instruction
//  fetch_stall    out  1   =1 while state REQ and no mem_ack this cycle (to ctrl)
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=IDLE, kill=0, redirect_pc=0, mem_req=0, mem_addr=0,
//    if_pc=0, if_inst=0, if_valid=0, fetch_stall=0.
//  - States: IDLE, REQ, HOLD. mem_req=(state==REQ); mem_addr=pc (combinational from pc).
//  - IDLE: unconditionally -> REQ on the first clock after rst deasserts.
//  - REQ, no ack: hold pc. A branch_flag sets kill=1 and redirect_pc=target (last wins).
//    if_valid<=0 unless stall=1 (outputs held).
//  - REQ, ack, (kill | branch_flag): discard rdata; pc<=branch target if branch_flag, else
//    redirect_pc; kill<=0; stay REQ; if_valid<=0. Same-cycle branch_flag beats kill.
//  - REQ, ack, clean, stall=0: if_pc<=pc, if_inst<=rdata, if_valid<=1, pc<=pc+PC_STEP,
//    stay REQ. Back-to-back fetch: new address next cycle, so zero-wait memory gives
//    1 instr/cycle. Latency ack->IF/ID input = 1 clock (registered outputs).
//  - REQ, ack, clean, stall=1: latch outputs as above, -> HOLD, pc unchanged.
//  - HOLD: mem_req=0, outputs held. A branch_flag sets kill=1 and redirect_pc=target.
//    On stall=0: pc<=kill ? redirect_pc : pc+PC_STEP, kill<=0, -> REQ. If kill: if_valid<=0.
//    If no kill: outputs stay valid one more cycle for IF/ID to capture, then clear.
//  - pc arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//  - stall=1 in REQ never drops an in-flight request; req stays high until ack.
//  - rst mid-request: immediate return to reset values. Any late mem_ack is ignored
//    (mem_req=0).
//  - Outputs and pc are registers. Only mem_req, mem_addr and fetch_stall are
//    combinational.
// STRUCTURE
//  - Shared defines file gains: `FetchIdle/`FetchReq/`FetchHold (2-bit encodings), `PcStep.
//    Reuse existing `ZeroWord, `InstAddrBus, `InstBus.
//  - Single module. The pc/redirect register and FSM are small enough that no sub-module
//    is warranted.
// TESTING
//  1 Reset, zero-wait memory (ack same cycle as req): mem_addr 0,4,8,C on consecutive
//    cycles; if_pc follows one clock later with if_valid=1.
//  2 Memory acks after 3 cycles: mem_addr held at 0x4 for 3 cycles, fetch_stall=1 for
//    2 cycles, then if_pc=0x4 for exactly one valid cycle.
//  3 branch_flag, target 0x100, while fetch of 0x8 outstanding: the 0x8 data is
//    discarded (if_valid=0); next mem_addr=0x100; if_pc=0x100 valid after its ack.
//  4 branch_flag same cycle as ack of 0x8, target 0x203: rdata discarded; next mem_addr=0x200.
//  5 stall=1 across an ack of 0x10 for 4 cycles: if_pc=0x10 valid and held, mem_req=0
//    in HOLD; after release next mem_addr=0x14.
//  6 RESET_PC=32'hFFFF_FFF8, zero-wait: fetches FFF8, FFFC, 0000, 0004. Assert rst while
//    req pending: all outputs 0 asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_pkg
// Brief  : Shared types, state encodings and helpers for the fetch stage.
// Rev    : 1.0
// ============================================================================
package if_fetch_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam logic [1:0] c_FETCH_IDLE = 2'd0;
  localparam logic [1:0] c_FETCH_REQ  = 2'd1;
  localparam logic [1:0] c_FETCH_HOLD = 2'd2;

  localparam inst_addr_t c_PC_STEP   = 32'd4;
  localparam inst_t      c_ZERO_WORD = 32'h0000_0000;

  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module : if_fetch
// Brief  : Instruction-fetch stage: owns the PC, runs a single-outstanding
//          req/ack fetch to instruction memory and feeds IF/ID.
// Rev    : 1.0
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter inst_addr_t PC_STEP  = c_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_stall
);

  logic [1:0] r_state;
  inst_addr_t r_pc;
  inst_addr_t r_redirect_pc;
  logic       r_kill;

  inst_addr_t w_target;
  inst_addr_t w_pc_seq;

  assign w_target    = align_word(branch_target);
  assign w_pc_seq    = r_pc + PC_STEP;
  assign mem_req     = (r_state == c_FETCH_REQ);
  // Address reads zero until the first request so reset presents all-zero outputs.
  assign mem_addr    = (r_state == c_FETCH_IDLE) ? c_ZERO_WORD : r_pc;
  assign fetch_stall = mem_req & ~mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_FETCH_IDLE;
      r_pc          <= RESET_PC;
      r_redirect_pc <= '0;
      r_kill        <= 1'b0;
      if_pc         <= '0;
      if_inst       <= c_ZERO_WORD;
      if_valid      <= 1'b0;
    end else begin
      case (r_state)
        c_FETCH_IDLE: r_state <= c_FETCH_REQ;

        c_FETCH_REQ: begin
          if (!mem_ack) begin
            if (branch_flag) begin
              r_kill        <= 1'b1;
              r_redirect_pc <= w_target;
            end
            if (!stall) begin
              if_valid <= 1'b0;
              if_inst  <= c_ZERO_WORD;
            end
          end else if (r_kill || branch_flag) begin
            // Returning word belongs to the wrong path; a fresh branch beats a stored one.
            r_pc     <= branch_flag ? w_target : r_redirect_pc;
            r_kill   <= 1'b0;
            if_valid <= 1'b0;
            if_inst  <= c_ZERO_WORD;
          end else begin
            if_pc    <= r_pc;
            if_inst  <= mem_rdata;
            if_valid <= 1'b1;
            if (stall) r_state <= c_FETCH_HOLD;
            else       r_pc    <= w_pc_seq;
          end
        end

        c_FETCH_HOLD: begin
          if (!stall) begin
            r_state <= c_FETCH_REQ;
            r_kill  <= 1'b0;
            if (branch_flag || r_kill) begin
              r_pc     <= branch_flag ? w_target : r_redirect_pc;
              if_valid <= 1'b0;
              if_inst  <= c_ZERO_WORD;
            end else begin
              r_pc <= w_pc_seq;
            end
          end else if (branch_flag) begin
            r_kill        <= 1'b1;
            r_redirect_pc <= w_target;
          end
        end

        default: r_state <= c_FETCH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_if_fetch
// Brief  : Directed scoreboard bench for if_fetch (default and wrapping PC).
// Rev    : 1.0
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        mem_req, mem_ack, if_valid, fetch_stall;
  logic [31:0] mem_addr, mem_rdata, if_pc, if_inst;

  logic        rst2 = 1'b1;
  logic        mem_req2, mem_ack2, if_valid2, fetch_stall2;
  logic [31:0] mem_addr2, mem_rdata2, if_pc2, if_inst2;

  int vectors = 0;
  int miscompares = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .if_valid(if_valid), .fetch_stall(fetch_stall)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .branch_flag(1'b0),
    .branch_target(32'h0), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .if_pc(if_pc2), .if_inst(if_inst2),
    .if_valid(if_valid2), .fetch_stall(fetch_stall2)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  // Memory model: acks once the request has waited 'lat' cycles.
  int   lat = 0;
  int   wcnt = 0;
  logic ack_en = 1'b1;
  always_comb mem_ack   = mem_req && ack_en && (wcnt >= lat);
  always_comb mem_rdata = mem_ack ? inst_of(mem_addr) : 32'hDEAD_BEEF;
  always @(posedge clk or posedge rst) begin
    if (rst)                     wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
  end

  logic ack_en2 = 1'b1, late_ack2 = 1'b0;
  always_comb mem_ack2   = (mem_req2 && ack_en2) || late_ack2;
  always_comb mem_rdata2 = inst_of(mem_addr2);

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    q.push_back({a, inst_of(a)});
  endtask

  // Pops one expectation per newly presented instruction of the main DUT.
  logic        pv = 1'b0;
  logic [31:0] ppc = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (if_valid && (!pv || if_pc != ppc)) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL sb_unexpected observed=%h expected=none", if_pc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_pc", if_pc, e.pc);
          chk("sb_inst", if_inst, e.inst);
        end
      end
      pv  = if_valid;
      ppc = if_pc;
    end
  end

  task automatic restart();
    #2;
    chk("sb_drained", 32'(q.size()), 32'd0);
    q.delete();
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; lat = 0; ack_en = 1'b1;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_fstall", {31'd0, fetch_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    @(negedge clk);

    // 1: zero-wait streaming
    restart();
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", mem_addr, 32'(4 * i));
      chk("t1_req", {31'd0, mem_req}, 32'd1);
      chk("t1_fstall", {31'd0, fetch_stall}, 32'd0);
      push(32'(4 * i));
      @(negedge clk);
    end
    chk("t1_valid", {31'd0, if_valid}, 32'd1);

    // 2: three-cycle memory on 0x4
    restart();
    push(32'h0);
    @(negedge clk);
    lat = 2; #1;
    chk("t2_addr_a", mem_addr, 32'h4);
    chk("t2_fstall_a", {31'd0, fetch_stall}, 32'd1);
    push(32'h4);
    @(negedge clk);
    chk("t2_addr_b", mem_addr, 32'h4);
    chk("t2_fstall_b", {31'd0, fetch_stall}, 32'd1);
    chk("t2_valid_b", {31'd0, if_valid}, 32'd0);
    chk("t2_inst_b", if_inst, 32'd0);
    @(negedge clk);
    chk("t2_addr_c", mem_addr, 32'h4);
    chk("t2_fstall_c", {31'd0, fetch_stall}, 32'd0);
    @(negedge clk);
    chk("t2_valid_d", {31'd0, if_valid}, 32'd1);
    chk("t2_addr_d", mem_addr, 32'h8);
    @(negedge clk);
    chk("t2_valid_e", {31'd0, if_valid}, 32'd0);

    // 3: branch while 0x8 outstanding
    restart();
    push(32'h0);
    @(negedge clk);
    push(32'h4);
    @(negedge clk);
    lat = 2; #1;
    chk("t3_addr_a", mem_addr, 32'h8);
    branch_flag = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    branch_flag = 1'b0; branch_target = 32'h0;
    chk("t3_addr_b", mem_addr, 32'h8);
    chk("t3_valid_b", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("t3_fstall_c", {31'd0, fetch_stall}, 32'd0);
    @(negedge clk);
    lat = 0; #1;
    chk("t3_addr_d", mem_addr, 32'h100);
    chk("t3_valid_d", {31'd0, if_valid}, 32'd0);
    push(32'h100);
    @(negedge clk);

    // 4: branch coincident with ack of 0x8, unaligned target
    restart();
    push(32'h0);
    @(negedge clk);
    push(32'h4);
    @(negedge clk);
    chk("t4_addr_a", mem_addr, 32'h8);
    branch_flag = 1'b1; branch_target = 32'h203;
    @(negedge clk);
    branch_flag = 1'b0; branch_target = 32'h0;
    chk("t4_addr_b", mem_addr, 32'h200);
    chk("t4_valid_b", {31'd0, if_valid}, 32'd0);
    push(32'h200);
    @(negedge clk);

    // 5: stall across ack of 0x10
    restart();
    for (int i = 0; i < 4; i++) begin
      push(32'(4 * i));
      @(negedge clk);
    end
    chk("t5_addr_a", mem_addr, 32'h10);
    stall = 1'b1;
    push(32'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold_req", {31'd0, mem_req}, 32'd0);
      chk("t5_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("t5_hold_pc", if_pc, 32'h10);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t5_addr_b", mem_addr, 32'h14);
    chk("t5_req_b", {31'd0, mem_req}, 32'd1);
    chk("t5_valid_b", {31'd0, if_valid}, 32'd1);
    chk("t5_pc_b", if_pc, 32'h10);
    push(32'h14);
    @(negedge clk);
    #2;
    rst = 1'b1;
    chk("t5_drained", 32'(q.size()), 32'd0);

    // 6: wrapping reset PC and reset during a pending request
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a = 32'hFFFF_FFF8 + 32'(4 * i);
      chk("t6_addr", mem_addr2, a);
      if (i > 0) begin
        chk("t6_pc", if_pc2, a - 32'd4);
        chk("t6_inst", if_inst2, inst_of(a - 32'd4));
        chk("t6_valid", {31'd0, if_valid2}, 32'd1);
      end
      @(negedge clk);
    end
    ack_en2 = 1'b0; #1;
    chk("t6_pc_last", if_pc2, 32'h4);
    chk("t6_addr_pend", mem_addr2, 32'h8);
    chk("t6_fstall", {31'd0, fetch_stall2}, 32'd1);
    @(negedge clk);
    chk("t6_req_pend", {31'd0, mem_req2}, 32'd1);
    #2; rst2 = 1'b1; #1;
    chk("t6_rst_req", {31'd0, mem_req2}, 32'd0);
    chk("t6_rst_addr", mem_addr2, 32'd0);
    chk("t6_rst_pc", if_pc2, 32'd0);
    chk("t6_rst_inst", if_inst2, 32'd0);
    chk("t6_rst_valid", {31'd0, if_valid2}, 32'd0);
    chk("t6_rst_fstall", {31'd0, fetch_stall2}, 32'd0);
    late_ack2 = 1'b1;
    @(negedge clk);
    chk("t6_late_valid", {31'd0, if_valid2}, 32'd0);
    chk("t6_late_pc", if_pc2, 32'd0);
    late_ack2 = 1'b0; ack_en2 = 1'b1; rst2 = 1'b0;
    @(negedge clk);
    chk("t6_restart_addr", mem_addr2, 32'hFFFF_FFF8);
    chk("t6_restart_req", {31'd0, mem_req2}, 32'd1);
    @(negedge clk);
    chk("t6_restart_pc", if_pc2, 32'hFFFF_FFF8);
    chk("t6_restart_valid", {31'd0, if_valid2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
